// File: rtl/fetch_pkg.sv
// Shared types and constants for the 8-bit processor instruction fetch unit.
// Holds the state encoding, widths, reset PC and the next-PC selection helper.
package fetch_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 8;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      REQ    = 3'd3,
      HOLD   = 3'd4
   } fetch_state_e;

   // Redirect target wins; otherwise sequential fetch, wrapping modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] next_pc(input logic              use_tgt,
                                                 input logic [ADDR_W-1:0] tgt,
                                                 input logic [ADDR_W-1:0] pc);
      if (use_tgt) begin
         next_pc = tgt;
      end else begin
         next_pc = pc + ADDR_W'(1);
      end
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of PC-register, instruction-memory, redirect and decode signals around the fetch unit.
// master = the fetch unit, slave = its surroundings (PC register, memory, execute, decode).
interface fetch_if;
   import fetch_pkg::*;

   logic [ADDR_W-1:0]  PCOut;
   logic [ADDR_W-1:0]  PCIn;
   logic               PCWrite;
   logic               MemReq;
   logic [ADDR_W-1:0]  MemAddr;
   logic               MemAck;
   logic [INSTR_W-1:0] MemData;
   logic               BranchTaken;
   logic [ADDR_W-1:0]  BranchTarget;
   logic [INSTR_W-1:0] IR;
   logic               IRValid;
   logic               IRReady;

   modport master (
      input  PCOut, MemAck, MemData, BranchTaken, BranchTarget, IRReady,
      output PCIn, PCWrite, MemReq, MemAddr, IR, IRValid
   );

   modport slave (
      output PCOut, MemAck, MemData, BranchTaken, BranchTarget, IRReady,
      input  PCIn, PCWrite, MemReq, MemAddr, IR, IRValid
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch controller: loads the PC register, reads one instruction byte,
// hands it to decode and applies branch redirects from execute.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic      Clock,
   input  logic      Reset,
   fetch_if.master   bus
);

   fetch_state_e       state_r,    state_s;
   logic [ADDR_W-1:0]  pc_in_r,    pc_in_s;
   logic               pc_write_r, pc_write_s;
   logic               mem_req_r,  mem_req_s;
   logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
   logic [INSTR_W-1:0] ir_r,       ir_s;
   logic               ir_valid_r, ir_valid_s;
   logic               pend_r,     pend_s;
   logic [ADDR_W-1:0]  pend_tgt_r, pend_tgt_s;
   logic               clear_pend_s;
   logic               redirect_s;
   logic [ADDR_W-1:0]  redirect_tgt_s;

   // A fresh pulse this cycle beats an older latched target.
   assign redirect_tgt_s = bus.BranchTaken ? bus.BranchTarget : pend_tgt_r;

   // Next-state and next-output logic of the fetch sequencer.
   always_comb begin
      state_s      = state_r;
      pc_in_s      = pc_in_r;
      pc_write_s   = 1'b0;
      mem_req_s    = mem_req_r;
      mem_addr_s   = mem_addr_r;
      ir_s         = ir_r;
      ir_valid_s   = ir_valid_r;
      clear_pend_s = 1'b0;
      redirect_s   = pend_r | bus.BranchTaken;
      case (state_r)
         INIT: begin
            state_s    = LOAD;
            pc_in_s    = RESET_PC;
            pc_write_s = 1'b1;
         end
         LOAD: begin
            state_s = SETTLE;
         end
         SETTLE: begin
            state_s    = REQ;
            mem_req_s  = 1'b1;
            mem_addr_s = bus.PCOut;
         end
         REQ: begin
            if (bus.MemAck) begin
               mem_req_s = 1'b0;
               if (pend_r) begin
                  // Stale fetch: drop the byte and restart at the redirect target.
                  state_s      = LOAD;
                  pc_in_s      = next_pc(1'b1, redirect_tgt_s, bus.PCOut);
                  pc_write_s   = 1'b1;
                  clear_pend_s = 1'b1;
               end else begin
                  state_s    = HOLD;
                  ir_s       = bus.MemData;
                  ir_valid_s = 1'b1;
               end
            end else begin
               state_s = REQ;
            end
         end
         HOLD: begin
            if (redirect_s || (ir_valid_r && bus.IRReady)) begin
               state_s      = LOAD;
               ir_valid_s   = 1'b0;
               pc_in_s      = next_pc(redirect_s, redirect_tgt_s, bus.PCOut);
               pc_write_s   = 1'b1;
               clear_pend_s = redirect_s;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s    = INIT;
            mem_req_s  = 1'b0;
            ir_valid_s = 1'b0;
         end
      endcase
   end

   // Redirect latch: remembers the latest branch seen while no instruction is held.
   always_comb begin
      pend_s     = pend_r;
      pend_tgt_s = pend_tgt_r;
      if (clear_pend_s) begin
         pend_s = 1'b0;
      end else if (bus.BranchTaken && (state_r != HOLD)) begin
         pend_s     = 1'b1;
         pend_tgt_s = bus.BranchTarget;
      end else begin
         pend_s = pend_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r    <= INIT;
         pc_in_r    <= RESET_PC;
         pc_write_r <= 1'b0;
         mem_req_r  <= 1'b0;
         mem_addr_r <= {ADDR_W{1'b0}};
         ir_r       <= {INSTR_W{1'b0}};
         ir_valid_r <= 1'b0;
         pend_r     <= 1'b0;
         pend_tgt_r <= {ADDR_W{1'b0}};
      end else begin
         state_r    <= state_s;
         pc_in_r    <= pc_in_s;
         pc_write_r <= pc_write_s;
         mem_req_r  <= mem_req_s;
         mem_addr_r <= mem_addr_s;
         ir_r       <= ir_s;
         ir_valid_r <= ir_valid_s;
         pend_r     <= pend_s;
         pend_tgt_r <= pend_tgt_s;
      end
   end

   assign bus.PCIn    = pc_in_r;
   assign bus.PCWrite = pc_write_r;
   assign bus.MemReq  = mem_req_r;
   assign bus.MemAddr = mem_addr_r;
   assign bus.IR      = ir_r;
   assign bus.IRValid = ir_valid_r;

endmodule
